// File: rtl/sr_rx_pkg.sv
// sr_rx_pkg: shared FSM state type and counter sizing for the shift-register readback receiver.
package sr_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        SHIFT = 2'd2
    } state_e;

    // The bit counter must also hold DATA_WIDTH itself, the frame-complete step.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sr_rx_channel.sv
// sr_rx_channel: one channel's staging register with synchronous clear and indexed single-bit write.
module sr_rx_channel
    import sr_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 170,
    parameter int IW         = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  we,
    input  logic [IW-1:0]         idx,
    input  logic                  din,
    output logic [DATA_WIDTH-1:0] stg
);

    logic [DATA_WIDTH-1:0] stg_q, stg_d;

    // Clear and write may coincide when a zero-delay frame captures bit 0 at its start edge.
    always_comb begin
        stg_d = clr ? '0 : stg_q;
        if (we) stg_d[idx] = din;
    end

    always_ff @(negedge clk or posedge rst)
        if (rst) stg_q <= '0;
        else     stg_q <= stg_d;

    assign stg = stg_q;

endmodule

// File: rtl/sr_readback_rx.sv
// sr_readback_rx: multi-channel shift-register readback receiver with programmable delay,
// selectable bit order and a valid/ready output with overrun reporting.
module sr_readback_rx
    import sr_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 170,
    parameter int NCH        = 4,
    parameter int DLY_W      = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [DLY_W-1:0]          read_delay,
    input  logic                      msb_first,
    input  logic [NCH-1:0]            data_in,
    output logic [NCH*DATA_WIDTH-1:0] dout,
    output logic                      valid,
    input  logic                      ready,
    output logic                      busy,
    output logic                      overrun
);

    localparam int CW = cnt_width(DATA_WIDTH);
    localparam int IW = $clog2(DATA_WIDTH);

    state_e                    state_q, state_d;
    logic [DLY_W-1:0]          dly_q, dly_d;
    logic [CW-1:0]             cnt_q, cnt_d, wcnt, widx;
    logic                      m_q, m_d, m_eff;
    logic [NCH*DATA_WIDTH-1:0] stg, dout_q, dout_d;
    logic                      valid_q, valid_d, overrun_q, overrun_d;
    logic                      clr, we, done, go;

    // The completion edge doubles as an IDLE edge so frames can run back to back.
    assign done = state_q == SHIFT && cnt_q == CW'(DATA_WIDTH) && !abort;
    assign go   = start && (state_q == IDLE || done);
    assign widx = m_eff ? CW'(DATA_WIDTH - 1) - wcnt : wcnt;

    always_comb begin
        state_d   = state_q;
        dly_d     = dly_q;
        cnt_d     = cnt_q;
        m_d       = m_q;
        dout_d    = dout_q;
        valid_d   = valid_q && !ready;
        overrun_d = 1'b0;
        clr       = 1'b0;
        we        = 1'b0;
        wcnt      = cnt_q;
        m_eff     = m_q;
        if (state_q != IDLE && abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == DELAY) begin
            we      = dly_q == '0;
            cnt_d   = we ? CW'(1) : cnt_q;
            state_d = we ? SHIFT : DELAY;
            dly_d   = we ? dly_q : dly_q - DLY_W'(1);
        end else if (state_q == SHIFT && !done) begin
            we    = 1'b1;
            cnt_d = cnt_q + CW'(1);
        end
        if (done) begin
            dout_d    = stg;
            valid_d   = 1'b1;
            overrun_d = valid_q && !ready;
            state_d   = IDLE;
            cnt_d     = '0;
        end
        if (go) begin
            m_d     = msb_first;
            m_eff   = msb_first;
            dly_d   = read_delay - DLY_W'(1);
            clr     = 1'b1;
            wcnt    = '0;
            we      = read_delay == '0;
            cnt_d   = we ? CW'(1) : '0;
            state_d = we ? SHIFT : DELAY;
        end
    end

    always_ff @(negedge clk or posedge rst)
        if (rst) begin
            state_q   <= IDLE;
            dly_q     <= '0;
            cnt_q     <= '0;
            m_q       <= 1'b0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dly_q     <= dly_d;
            cnt_q     <= cnt_d;
            m_q       <= m_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        sr_rx_channel #(.DATA_WIDTH(DATA_WIDTH), .IW(IW)) u_ch (
            .clk (clk),
            .rst (rst),
            .clr (clr),
            .we  (we),
            .idx (widx[IW-1:0]),
            .din (data_in[g]),
            .stg (stg[g*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    assign dout    = dout_q;
    assign valid   = valid_q;
    assign busy    = state_q != IDLE;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_sr_readback_rx.sv
// tb_sr_readback_rx: randomized scenario bench for sr_readback_rx against a bit-placement reference model.
module tb_sr_readback_rx;

    localparam int DW    = 170;
    localparam int NCH   = 4;
    localparam int DLY_W = 3;

    logic              clk = 1'b1;
    logic              rst;
    logic              start, abort, msb_first, ready;
    logic [DLY_W-1:0]  read_delay;
    logic [NCH-1:0]    data_in;
    logic [NCH*DW-1:0] dout;
    logic              valid, busy, overrun;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0]     ser [NCH];
    logic [NCH*DW-1:0] exp_dout, first_dout;
    logic              first_valid, first_overrun;
    int                busy_bad, vcount, ovcount;

    sr_readback_rx #(.DATA_WIDTH(DW), .NCH(NCH), .DLY_W(DLY_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .read_delay (read_delay),
        .msb_first  (msb_first),
        .data_in    (data_in),
        .dout       (dout),
        .valid      (valid),
        .ready      (ready),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // First serial bit of a channel lands at the top index when m=1, at index 0 otherwise.
    function automatic logic [NCH*DW-1:0] model(input bit m);
        logic [NCH*DW-1:0] w = '0;
        for (int c = 0; c < NCH; c++)
            for (int i = 0; i < DW; i++)
                w[c*DW + (m ? DW - 1 - i : i)] = ser[c][i];
        return w;
    endfunction

    task automatic randomize_ser();
        for (int c = 0; c < NCH; c++)
            for (int i = 0; i < DW; i++)
                ser[c][i] = 1'($urandom);
    endtask

    // Edge j=0 is the start edge; serial bit i is presented for edge d+i.
    task automatic drive_frame(input int d, input bit m, input int n, input bit hold, input int extra_j);
        busy_bad = 0;
        vcount   = 0;
        ovcount  = 0;
        for (int j = 0; j < n; j++) begin
            start      = (j == 0) || hold || (j == extra_j);
            read_delay = start ? DLY_W'(d) : DLY_W'($urandom);
            msb_first  = start ? m : 1'($urandom);
            for (int c = 0; c < NCH; c++)
                data_in[c] = (j >= d && j - d < DW) ? ser[c][j-d] : 1'($urandom);
            tick();
            if (busy !== 1'b1) busy_bad++;
            if (j == 0) begin
                first_valid   = valid;
                first_overrun = overrun;
                first_dout    = dout;
            end else if (valid === 1'b1) vcount++;
            if (overrun === 1'b1) ovcount++;
        end
        start     = 1'b0;
        msb_first = 1'($urandom);
        data_in   = NCH'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; abort = 0; ready = 0; data_in = '0; read_delay = '0; msb_first = 0;
        repeat (3) tick();
        checks++; if (dout !== '0) begin errors++; $display("FAIL reset_dout got %h exp 0", dout); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
        rst = 1'b0;
        tick();
        exp_dout = '0;
    endtask

    task automatic test_msb_pattern();
        logic [175:0]      rep = {22{8'hA5}};
        logic [DW-1:0]     pat;
        logic [NCH*DW-1:0] expw;
        for (int c = 0; c < NCH; c++) begin
            pat = rep[DW-1:0] ^ DW'(c);
            for (int i = 0; i < DW; i++) ser[c][i] = pat[DW-1-i];
            expw[c*DW +: DW] = pat;
        end
        ready = 1'b1;
        drive_frame(0, 1'b1, DW, 1'b0, -1);
        checks++; if (busy_bad !== 0) begin errors++; $display("FAIL msb_busy_during got %0d low edges exp 0", busy_bad); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL msb_early_valid got %b exp 0", valid); end
        tick();
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL msb_valid got %b exp 1", valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL msb_busy_done got %b exp 0", busy); end
        checks++; if (dout !== expw) begin errors++; $display("FAIL msb_dout got %h exp %h", dout, expw); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL msb_overrun got %b exp 0", overrun); end
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL msb_valid_drop got %b exp 0", valid); end
        exp_dout = expw;
    endtask

    task automatic test_delay_walk();
        logic [NCH*DW-1:0] expw = '0;
        for (int c = 0; c < NCH; c++) begin
            ser[c] = '0;
            ser[c][c*37+5] = 1'b1;
            expw[c*DW + c*37 + 5] = 1'b1;
        end
        ready = 1'b1;
        drive_frame(2, 1'b0, DW + 2, 1'b0, -1);
        checks++; if (vcount !== 0 || valid !== 1'b0) begin errors++; $display("FAIL walk_early_valid got %0d exp 0", vcount); end
        tick();
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL walk_valid got %b exp 1", valid); end
        checks++; if (dout !== expw) begin errors++; $display("FAIL walk_dout got %h exp %h", dout, expw); end
        tick();
        exp_dout = expw;
    endtask

    task automatic test_random();
        int d;
        bit m;
        for (int r = 0; r < 6; r++) begin
            d = $urandom_range(0, 7);
            m = 1'($urandom);
            randomize_ser();
            ready = 1'b1;
            drive_frame(d, m, d + DW, 1'b0, -1);
            checks++; if (busy_bad !== 0 || vcount !== 0) begin errors++; $display("FAIL rand_timing r=%0d busy_low %0d early_valid %0d exp 0 0", r, busy_bad, vcount); end
            tick();
            exp_dout = model(m);
            checks++; if (valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rand_done r=%0d valid %b busy %b exp 1 0", r, valid, busy); end
            checks++; if (dout !== exp_dout) begin errors++; $display("FAIL rand_dout r=%0d d=%0d m=%0d got %h exp %h", r, d, m, dout, exp_dout); end
            tick();
        end
    endtask

    task automatic test_overrun();
        int da, db;
        bit ma, mb;
        logic [NCH*DW-1:0] exp_a;
        ready = 1'b0;
        da = $urandom_range(0, 7); ma = 1'($urandom);
        randomize_ser();
        exp_a = model(ma);
        drive_frame(da, ma, da + DW, 1'b0, -1);
        db = $urandom_range(0, 7); mb = 1'($urandom);
        randomize_ser();
        drive_frame(db, mb, db + DW, 1'b0, -1);
        checks++; if (first_valid !== 1'b1 || first_overrun !== 1'b0) begin errors++; $display("FAIL ovr_first valid %b overrun %b exp 1 0", first_valid, first_overrun); end
        checks++; if (first_dout !== exp_a) begin errors++; $display("FAIL ovr_first_dout got %h exp %h", first_dout, exp_a); end
        checks++; if (ovcount !== 0 || busy_bad !== 0) begin errors++; $display("FAIL ovr_during overruns %0d busy_low %0d exp 0 0", ovcount, busy_bad); end
        tick();
        exp_dout = model(mb);
        checks++; if (overrun !== 1'b1 || valid !== 1'b1) begin errors++; $display("FAIL ovr_pulse overrun %b valid %b exp 1 1", overrun, valid); end
        checks++; if (dout !== exp_dout) begin errors++; $display("FAIL ovr_dout got %h exp %h", dout, exp_dout); end
        tick();
        checks++; if (overrun !== 1'b0 || valid !== 1'b1) begin errors++; $display("FAIL ovr_after overrun %b valid %b exp 0 1", overrun, valid); end
        ready = 1'b1;
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ovr_consume got %b exp 0", valid); end
        ready = 1'b0;
        randomize_ser();
        drive_frame(1, 1'b1, 1 + DW, 1'b0, -1);
        randomize_ser();
        drive_frame(0, 1'b0, DW, 1'b0, -1);
        ready = 1'b1;
        tick();
        exp_dout = model(1'b0);
        checks++; if (overrun !== 1'b0 || valid !== 1'b1) begin errors++; $display("FAIL ovr_same_edge overrun %b valid %b exp 0 1", overrun, valid); end
        checks++; if (dout !== exp_dout) begin errors++; $display("FAIL ovr_same_edge_dout got %h exp %h", dout, exp_dout); end
        tick();
    endtask

    task automatic test_abort();
        int d;
        bit m;
        ready = 1'b1;
        d = $urandom_range(0, 7); m = 1'($urandom);
        randomize_ser();
        drive_frame(d, m, d + 100, 1'b1, -1);
        start = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || valid !== 1'b0 || vcount !== 0) begin errors++; $display("FAIL abort_state busy %b valid %b early %0d exp 0 0 0", busy, valid, vcount); end
        checks++; if (dout !== exp_dout) begin errors++; $display("FAIL abort_dout got %h exp %h", dout, exp_dout); end
        d = $urandom_range(0, 7); m = 1'($urandom);
        randomize_ser();
        drive_frame(d, m, d + DW, 1'b0, -1);
        checks++; if (busy_bad !== 0) begin errors++; $display("FAIL abort_restart busy low %0d edges exp 0", busy_bad); end
        tick();
        exp_dout = model(m);
        checks++; if (valid !== 1'b1 || dout !== exp_dout) begin errors++; $display("FAIL abort_next valid %b dout %h exp 1 %h", valid, dout, exp_dout); end
        tick();
    endtask

    task automatic test_reset_mid();
        int extra;
        bit m;
        ready = 1'b1;
        randomize_ser();
        drive_frame(3, 1'($urandom), 53, 1'b0, -1);
        #2 rst = 1'b1;
        #1;
        checks++; if (dout !== '0 || valid !== 1'b0) begin errors++; $display("FAIL rstmid_out dout %h valid %b exp 0 0", dout, valid); end
        checks++; if (busy !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL rstmid_flags busy %b overrun %b exp 0 0", busy, overrun); end
        #1 rst = 1'b0;
        tick();
        m = 1'($urandom);
        randomize_ser();
        drive_frame(3, m, 3 + DW, 1'b0, 20);
        tick();
        exp_dout = model(m);
        checks++; if (valid !== 1'b1 || dout !== exp_dout) begin errors++; $display("FAIL busy_start_frame valid %b dout %h exp 1 %h", valid, dout, exp_dout); end
        extra = 0;
        repeat (DW + 30) begin
            tick();
            if (valid === 1'b1 || busy === 1'b1) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL busy_start_ignored got %0d active cycles exp 0", extra); end
    endtask

    initial begin
        test_reset();
        test_msb_pattern();
        test_delay_walk();
        test_random();
        test_overrun();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
